// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Purpose  : Streams host program bytes into RAM while holding the CPU in
//            reset. Optional macro LOADER_CHECKSUM_EN treats the last byte
//            as a checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   byte_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    error_q, error_d;
  logic                    w_hs;
  logic                    w_data_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              sum_q, sum_d;
`endif

  assign w_hs = in_valid && (state_q == LOAD);

`ifdef LOADER_CHECKSUM_EN
  assign w_data_byte = !in_last;
`else
  assign w_data_byte = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      error_q <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    error_d = error_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
          count_d = '0;
          error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (w_hs) begin
          // The byte count doubles as the next session address.
          if (w_data_byte) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_WIDTH-1:0];
            wdata_d = in_data;
            count_d = count_q + 1'b1;
          end
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + 8'(in_data);
`endif
          if (in_last) begin
            state_d = FLUSH;
`ifdef LOADER_CHECKSUM_EN
            if (sum_d != 8'd0) error_d = 1'b1;
`endif
          end else if (count_q == LAST_ADDR) begin
            state_d = FLUSH;
            error_d = 1'b1;
          end
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == LOAD);
  assign cpu_hold   = (state_q == LOAD) || (state_q == FLUSH);
  assign done       = (state_q == DONE);
  assign error      = error_q;
  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign byte_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Self-checking bench for program_loader (table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;
  localparam int DW = 8;
  localparam int AW = 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   byte_count;

  program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_LOAD, M_FLUSH, M_DONE} mstate_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int n; bit last; bit gaps; logic [7:0] d [17]; int exp_w; bit exp_e; } vec_t;

  mstate_t     m_state = M_IDLE;
  logic [AW:0] m_cnt = '0;
  bit          m_err = 1'b0;
  logic [7:0]  m_sum = '0;
  wr_t         sb[$];
  vec_t        tbl[5];
  int          errors = 0;
  int          checks = 0;
  int          nw = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: pre-edge state checks, model update, post-edge write check.
  task automatic tick();
    wr_t e;
    chk("in_ready", in_ready, m_state == M_LOAD);
    chk("cpu_hold", cpu_hold, (m_state == M_LOAD) || (m_state == M_FLUSH));
    chk("done", done, m_state == M_DONE);
    chk("byte_count", byte_count, m_cnt);
    if (m_state == M_DONE) chk("error", error, m_err);
    if (!reset) begin
      m_state = M_IDLE; m_cnt = '0; m_err = 1'b0; m_sum = '0;
      sb.delete();
    end else begin
      case (m_state)
        M_IDLE, M_DONE: if (start) begin
          m_state = M_LOAD; m_cnt = '0; m_err = 1'b0; m_sum = '0;
        end
        M_LOAD: if (in_valid) begin
          m_sum = m_sum + in_data;
          if (!(CK && in_last)) begin
            sb.push_back('{addr: m_cnt[AW-1:0], data: in_data});
            m_cnt = m_cnt + 1'b1;
          end
          if (in_last) begin
            m_state = M_FLUSH;
            if (CK && m_sum != 8'd0) m_err = 1'b1;
          end else if (m_cnt == (AW+1)'(1 << AW)) begin
            m_state = M_FLUSH;
            m_err = 1'b1;
          end
        end
        M_FLUSH: m_state = M_DONE;
        default: m_state = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ram_we", ram_we, 1'b1);
      chk("ram_addr", ram_addr, e.addr);
      chk("ram_wdata", ram_wdata, e.data);
      nw++;
    end else begin
      chk("ram_we_quiet", ram_we, 1'b0);
    end
  endtask

  task automatic run_session(input int idx);
    nw = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < tbl[idx].n; i++) begin
      if (tbl[idx].gaps) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = tbl[idx].d[i];
      in_last  = tbl[idx].last && (i == tbl[idx].n - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) tick();
    chk("sess_writes", nw, tbl[idx].exp_w);
    chk("sess_done", done, 1'b1);
    chk("sess_error", error, tbl[idx].exp_e);
    chk("sess_count", byte_count, tbl[idx].exp_w);
    chk("sess_hold", cpu_hold, 1'b0);
  endtask

  initial begin
    tbl[0].n = 3; tbl[0].last = 1; tbl[0].gaps = 0;
    tbl[0].d[0] = 8'h15; tbl[0].d[1] = 8'h6A; tbl[0].d[2] = 8'hF0;
    tbl[0].exp_w = CK ? 2 : 3; tbl[0].exp_e = CK;
    tbl[1].n = 16; tbl[1].last = 1; tbl[1].gaps = 1;
    for (int i = 0; i < 16; i++) tbl[1].d[i] = 8'(i);
    tbl[1].exp_w = CK ? 15 : 16; tbl[1].exp_e = CK;
    tbl[2].n = 17; tbl[2].last = 0; tbl[2].gaps = 0;
    for (int i = 0; i < 17; i++) tbl[2].d[i] = 8'(8'h40 + i);
    tbl[2].exp_w = 16; tbl[2].exp_e = 1;
    for (int k = 3; k < 5; k++) begin
      tbl[k].n = 4; tbl[k].last = 1; tbl[k].gaps = 0;
      tbl[k].d[0] = 8'h15; tbl[k].d[1] = 8'h6A; tbl[k].d[2] = 8'hF0;
      tbl[k].exp_w = CK ? 3 : 4;
    end
    tbl[3].d[3] = 8'h91; tbl[3].exp_e = 0;
    tbl[4].d[3] = 8'h92; tbl[4].exp_e = CK;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, '0);
    chk("rst_ram_wdata", ram_wdata, '0);
    chk("rst_cpu_hold", cpu_hold, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_byte_count", byte_count, '0);
    reset = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) run_session(k);

    // Reset mid-load; the handshake on the reset edge must not write.
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hA1; tick();
    in_data = 8'hA2; tick();
    in_data = 8'hA3; reset = 1'b0; tick();
    reset = 1'b1; in_valid = 1'b0;
    chk("midrst_ram_addr", ram_addr, '0);
    chk("midrst_ram_wdata", ram_wdata, '0);
    chk("midrst_error", error, 1'b0);
    tick();
    run_session(0);

    // Start during LOAD is ignored; start in DONE opens a new session.
    nw = 0;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; start = 1'b1; tick(); start = 1'b0;
    in_data = 8'h33; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) tick();
    chk("ignstart_writes", nw, CK ? 2 : 3);
    chk("ignstart_done", done, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_done", done, 1'b0);
    chk("restart_count", byte_count, '0);
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) tick();
    chk("restart_end_done", done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of program bytes and RAM write data.
REQ-002 Parameter ADDR_WIDTH, default 4, width of RAM write address and byte counter.
REQ-003 Port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk edge).
REQ-005 Port start  input  1  begin a load session; sampled only in IDLE or DONE.
REQ-006 Port in_data  input  DATA_WIDTH  program byte from host.
REQ-007 Port in_valid  input  1  in_data valid.
REQ-008 Port in_last  input  1  qualifies final byte of session; meaningful only with in_valid.
REQ-009 Port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port ram_we  output  1  one-cycle RAM write strobe.
REQ-011 Port ram_addr  output  ADDR_WIDTH  RAM write address.
REQ-012 Port ram_wdata  output  DATA_WIDTH  RAM write data.
REQ-013 Port cpu_hold  output  1  holds the CPU in reset while memory is being written.
REQ-014 Port done  output  1  session complete, level until next start or reset.
REQ-015 Port error  output  1  session ended abnormally, valid while done=1.
REQ-016 Port byte_count  output  ADDR_WIDTH+1  number of bytes written to RAM this session.

Function
REQ-017 States SHALL be IDLE, LOAD, FLUSH, DONE; encoding free.
REQ-018 IDLE/DONE: start=1 -> LOAD; byte_count, write address, error, done cleared on that edge.
REQ-019 LOAD: in_ready=1 combinationally; handshake = in_valid & in_ready on rising edge.
REQ-020 Each accepted data byte SHALL produce ram_we=1 on the following cycle with ram_addr = session address, ram_wdata = byte; write latency exactly 1 cycle.
REQ-021 Address starts at 0, increments by 1 per written byte; byte_count increments in same cycle as ram_we.
REQ-022 Back-to-back handshakes every cycle SHALL be supported without loss.
REQ-023 Accepted byte with in_last=1 -> FLUSH; in_ready=0 in FLUSH.
REQ-024 FLUSH lasts exactly 1 cycle (completes final write) then -> DONE.
REQ-025 Overflow: a data byte accepted at address 2^ADDR_WIDTH-1 without in_last SHALL be written, then error=1 and -> FLUSH; no address wrap-around write.
REQ-026 cpu_hold=1 in LOAD and FLUSH, 0 in IDLE and DONE.
REQ-027 DONE: done=1, in_ready=0, ram_we=0; error holds its value.
REQ-028 start while in LOAD or FLUSH SHALL be ignored.
REQ-029 ram_we=0 in every cycle not following a handshake; ram_addr/ram_wdata hold last values.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE from any state, including mid-LOAD.
REQ-031 Reset values: in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=0, done=0, error=0, byte_count=0.
REQ-032 A pending write scheduled by a handshake on the reset edge SHALL be discarded.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN: when defined, the in_last byte is a checksum, not written to RAM; error=1 in DONE if 8-bit modulo sum of all session bytes including checksum != 0.
REQ-034 Without LOADER_CHECKSUM_EN the in_last byte is an ordinary data byte written to RAM; no checksum logic present.
REQ-035 With LOADER_CHECKSUM_EN, overflow (REQ-025) SHALL also set error regardless of checksum.

Verification
REQ-036 Reset, then start, bytes 0x15,0x6A,0xF0 (last) one per cycle -> writes addr 0/1/2 data 15/6A/F0, byte_count=3, done=1, error=0, cpu_hold 1 during LOAD/FLUSH (no macro).
REQ-037 Same with LOADER_CHECKSUM_EN, checksum byte 0x91 -> 3 writes, done=1, error=0; checksum 0x92 -> error=1.
REQ-038 16 bytes 0x00..0x0F with in_valid toggling every other cycle, last on 0x0F -> 16 writes addr 0..15, error=0, byte_count=16.
REQ-039 17 bytes without in_last -> 16 writes, no write to addr 0 again, error=1, done=1, cpu_hold=0.
REQ-040 reset=0 after 2 of 4 bytes -> IDLE, ram_we=0 next cycle, all outputs at reset values; new start restarts at addr 0.
REQ-041 start pulsed during LOAD -> no effect on address or count; start in DONE -> new session, done=0.
